// File: rtl/alu_rpn_sequencer.sv
// Purpose: RPN operand/opcode entry stage feeding a combinational ALU and capturing its result/flags.
// Latency: result/flags registered 2 clocks after the cycle enter is seen in S_OP (1-cycle EXEC state).
// Backpressure: none; button edges act immediately, undo wins over enter, edges in S_EXEC are dropped.
module alu_rpn_sequencer #(
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] data_in,
    input  logic [1:0]   op_in,
    input  logic         enter,
    input  logic         undo,
    input  logic [M-1:0] alu_result,
    input  logic [4:0]   alu_flags,
    output logic [M-1:0] alu_a,
    output logic [M-1:0] alu_b,
    output logic [1:0]   alu_opcode,
    output logic [M-1:0] display,
    output logic [4:0]   flags_out,
    output logic [3:0]   state_leds,
    output logic         result_valid
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic         enter_q, undo_q;
    logic [M-1:0] a_q, a_d;
    logic [M-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;
    logic [M-1:0] res_q, res_d;
    logic [4:0]   flg_q, flg_d;

    logic ent_p, und_p, ent_act;

    // One pulse per button press; undo takes priority over a simultaneous enter.
    assign ent_p   = enter & ~enter_q;
    assign und_p   = undo & ~undo_q;
    assign ent_act = ent_p & ~und_p;

    // State, edge-detect and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            enter_q <= 1'b0;
            undo_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            enter_q <= enter;
            undo_q  <= undo;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    // Next-state: RPN entry walk, undo steps back one stage.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_A:     if (ent_act) state_d = S_B;
            S_B:     if (und_p) state_d = S_A;  else if (ent_act) state_d = S_OP;
            S_OP:    if (und_p) state_d = S_B;  else if (ent_act) state_d = S_EXEC;
            S_EXEC:  state_d = S_RES;
            S_RES:   if (und_p) state_d = S_OP; else if (ent_act) state_d = S_B;
            default: state_d = S_A;
        endcase
    end

    // Register captures: operands on enter, ALU output in EXEC, result chained into A from RES.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        res_d = res_q;
        flg_d = flg_q;
        unique case (state_q)
            S_A:     if (ent_act) a_d = data_in;
            S_B:     if (ent_act) b_d = data_in;
            S_OP:    if (ent_act) op_d = op_in;
            S_EXEC: begin
                res_d = alu_result;
                flg_d = alu_flags;
            end
            S_RES:   if (ent_act) a_d = res_q;
            default: ;
        endcase
    end

    // Outputs: ALU operands straight from registers, display/LEDs decoded from state.
    always_comb begin
        alu_a        = a_q;
        alu_b        = b_q;
        alu_opcode   = op_q;
        flags_out    = flg_q;
        display      = data_in;
        state_leds   = 4'b0001;
        result_valid = 1'b0;
        unique case (state_q)
            S_A:     ;
            S_B:     state_leds = 4'b0010;
            S_OP: begin
                state_leds = 4'b0100;
                display    = {{(M-2){1'b0}}, op_in};
            end
            S_EXEC: begin
                state_leds = 4'b0100;
                display    = res_q;
            end
            S_RES: begin
                state_leds   = 4'b1000;
                display      = res_q;
                result_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_rpn_sequencer.sv
// Purpose: directed self-checking bench for alu_rpn_sequencer with a behavioural ALU in the loop.
// Latency: checks the 2-clock enter-to-result path and the 1-cycle EXEC state.
// Backpressure: exercises held buttons, simultaneous enter/undo and reset during EXEC.
module tb_alu_rpn_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic [1:0] op_in;
    logic       enter, undo;
    logic [7:0] alu_result;
    logic [4:0] alu_flags;
    logic [7:0] alu_a, alu_b, display;
    logic [1:0] alu_opcode;
    logic [4:0] flags_out;
    logic [3:0] state_leds;
    logic       result_valid;

    int checks = 0;
    int errors = 0;

    alu_rpn_sequencer #(.M(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .op_in        (op_in),
        .enter        (enter),
        .undo         (undo),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .display      (display),
        .flags_out    (flags_out),
        .state_leds   (state_leds),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 00 SUB (C = borrow), 01 ADD, 10 OR, 11 AND; flags {N,Z,C,V,P}, P = odd parity.
    always_comb begin
        logic [8:0] w;
        logic       c, v;
        w = 9'd0;
        c = 1'b0;
        v = 1'b0;
        case (alu_opcode)
            2'b00: begin
                w = {1'b0, alu_a} - {1'b0, alu_b};
                c = w[8];
                v = (alu_a[7] != alu_b[7]) && (w[7] != alu_a[7]);
            end
            2'b01: begin
                w = {1'b0, alu_a} + {1'b0, alu_b};
                c = w[8];
                v = (alu_a[7] == alu_b[7]) && (w[7] != alu_a[7]);
            end
            2'b10: w = {1'b0, alu_a | alu_b};
            default: w = {1'b0, alu_a & alu_b};
        endcase
        alu_result = w[7:0];
        alu_flags  = {w[7], (w[7:0] == 8'd0), c, v, ^w[7:0]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One button press: rise for one clock, then release for one clock.
    task automatic press(input bit is_undo, input logic [7:0] d, input logic [1:0] o);
        data_in = d;
        op_in   = o;
        if (is_undo) undo = 1'b1; else enter = 1'b1;
        tick();
        enter = 1'b0;
        undo  = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp_res;
        logic [4:0] exp_flg;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'h05, 8'h03, 2'b00, 8'h02, 5'b00001};
        vecs[1] = '{8'h7F, 8'h01, 2'b01, 8'h80, 5'b10011};
        vecs[2] = '{8'h03, 8'h05, 2'b00, 8'hFE, 5'b10101};
        vecs[3] = '{8'hF0, 8'h0F, 2'b10, 8'hFF, 5'b10000};
        vecs[4] = '{8'hF0, 8'h0F, 2'b11, 8'h00, 5'b01000};
        vecs[5] = '{8'h80, 8'h01, 2'b00, 8'h7F, 5'b00011};

        rst_n   = 1'b0;
        enter   = 1'b0;
        undo    = 1'b0;
        data_in = 8'h5A;
        op_in   = 2'b00;
        #1;
        check("reset_leds", state_leds, 4'b0001);
        check("reset_alu_a", alu_a, 8'h00);
        check("reset_flags", flags_out, 5'd0);
        check("reset_valid", result_valid, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_alu_a", alu_a, 8'h00);
        check("idle_alu_b", alu_b, 8'h00);
        check("idle_flags", flags_out, 5'd0);
        check("idle_leds", state_leds, 4'b0001);
        check("idle_display_live", display, 8'h5A);
        data_in = 8'hC3;
        #1;
        check("idle_display_follow", display, 8'hC3);

        // Table: enter A, B, op; check 2 clocks later; undo back to S_A.
        for (int i = 0; i < 6; i++) begin
            press(1'b0, vecs[i].a, 2'b00);
            check($sformatf("v%0d_leds_b", i), state_leds, 4'b0010);
            press(1'b0, vecs[i].b, 2'b00);
            check($sformatf("v%0d_leds_op", i), state_leds, 4'b0100);
            op_in = vecs[i].op;
            #1;
            check($sformatf("v%0d_disp_op", i), display, {6'd0, vecs[i].op});
            press(1'b0, 8'h00, vecs[i].op);
            check($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
            check($sformatf("v%0d_alu_b", i), alu_b, vecs[i].b);
            check($sformatf("v%0d_opcode", i), alu_opcode, vecs[i].op);
            check($sformatf("v%0d_display", i), display, vecs[i].exp_res);
            check($sformatf("v%0d_flags", i), flags_out, vecs[i].exp_flg);
            check($sformatf("v%0d_leds_res", i), state_leds, 4'b1000);
            check($sformatf("v%0d_valid", i), result_valid, 1'b1);
            press(1'b1, 8'h00, 2'b00);
            check($sformatf("v%0d_undo_op", i), state_leds, 4'b0100);
            check($sformatf("v%0d_undo_flags_kept", i), flags_out, vecs[i].exp_flg);
            press(1'b1, 8'h00, 2'b00);
            press(1'b1, 8'h00, 2'b00);
            check($sformatf("v%0d_undo_a", i), state_leds, 4'b0001);
        end

        // Chain: 7F+01 -> 80, then enter from S_RES loads A=80, add 80 -> 00 with Z,C,V.
        press(1'b0, 8'h7F, 2'b00);
        press(1'b0, 8'h01, 2'b00);
        press(1'b0, 8'h00, 2'b01);
        check("chain1_display", display, 8'h80);
        check("chain1_flags", flags_out, 5'b10011);
        press(1'b0, 8'h11, 2'b00);
        check("chain_leds_b", state_leds, 4'b0010);
        check("chain_alu_a", alu_a, 8'h80);
        press(1'b0, 8'h80, 2'b00);
        press(1'b0, 8'h00, 2'b01);
        check("chain2_display", display, 8'h00);
        check("chain2_flags", flags_out, 5'b01110);

        // Held enter in S_A advances once; undo in S_A does nothing.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        press(1'b1, 8'h00, 2'b00);
        check("undo_in_a", state_leds, 4'b0001);
        data_in = 8'h21;
        enter   = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("held_enter_leds", state_leds, 4'b0010);
        check("held_enter_a", alu_a, 8'h21);
        enter = 1'b0;
        tick();
        press(1'b0, 8'h09, 2'b00);
        check("simul_pre_leds", state_leds, 4'b0100);
        // Enter and undo rise together in S_OP: undo wins, op not captured.
        op_in = 2'b11;
        enter = 1'b1;
        undo  = 1'b1;
        tick();
        enter = 1'b0;
        undo  = 1'b0;
        tick();
        check("simul_leds", state_leds, 4'b0010);
        check("simul_opcode", alu_opcode, 2'b00);
        check("simul_flags", flags_out, 5'd0);

        // Reset during S_EXEC clears everything without capture.
        press(1'b0, 8'h0A, 2'b00);
        op_in = 2'b01;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check("exec_leds", state_leds, 4'b0100);
        check("exec_valid", result_valid, 1'b0);
        check("exec_opcode", alu_opcode, 2'b01);
        data_in = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_alu_a", alu_a, 8'h00);
        check("arst_alu_b", alu_b, 8'h00);
        check("arst_opcode", alu_opcode, 2'b00);
        check("arst_display", display, 8'h00);
        check("arst_flags", flags_out, 5'd0);
        check("arst_valid", result_valid, 1'b0);
        check("arst_leds", state_leds, 4'b0001);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_leds", state_leds, 4'b0001);
        check("post_rst_flags", flags_out, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
